// File: rtl/poly_synth_core.sv
// poly_synth_core: NUM_VOICES phase-accumulator voices sharing one waveshape, mixed to one PWM-driven sample.
// Optional build macro: POLY_MIX_SAT_EN selects a 2x-gain saturating mix instead of the plain average.
`default_nettype none

module poly_synth_core #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_W   = 8
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             en,
  input  logic [NUM_VOICES-1:0]            voice_on,
  input  logic [NUM_VOICES*PHASE_W-1:0]    phase_inc,
  input  logic [1:0]                       mode,
  output logic [SAMPLE_W-1:0]              sample_o,
  output logic                             sample_valid,
  output logic                             pwm_o,
  output logic [$clog2(NUM_VOICES+1)-1:0]  active_cnt
);

  localparam int LOG2V = $clog2(NUM_VOICES);
  localparam int SUM_W = SAMPLE_W + LOG2V;
  localparam int CNT_W = $clog2(NUM_VOICES+1);
  localparam logic [SAMPLE_W-1:0] SMAX = '1;
`ifdef POLY_MIX_SAT_EN
  localparam int MIX_SH = (LOG2V > 0) ? LOG2V - 1 : 0;
`else
  localparam int MIX_SH = LOG2V;
`endif

  localparam logic [1:0] MODE_SQUARE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  logic [SAMPLE_W-1:0] pwm_cnt;
  logic                tick;
  logic [NUM_VOICES-1:0] active;
  logic [PHASE_W-1:0]  acc   [NUM_VOICES];
  logic [SAMPLE_W-1:0] vsamp [NUM_VOICES];
  logic [SUM_W-1:0]    sum;
  logic [SAMPLE_W-1:0] mix;
  logic [CNT_W-1:0]    cnt_next;

  assign tick = en && (pwm_cnt == SMAX);

  function automatic logic [SAMPLE_W-1:0] shape(input logic [SAMPLE_W-1:0] p,
                                                input logic [1:0]          m);
    logic [SAMPLE_W-1:0] dbl;
    dbl = {p[SAMPLE_W-2:0], 1'b0};
    case (m)
      MODE_SQUARE: shape = p[SAMPLE_W-1] ? SMAX : '0;
      MODE_SAW:    shape = p;
      MODE_TRI:    shape = p[SAMPLE_W-1] ? ~dbl : dbl;
      default:     shape = (p[SAMPLE_W-1 -: 2] == 2'b00) ? SMAX : '0;
    endcase
  endfunction

  generate
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      logic [PHASE_W-1:0] inc;
      assign inc      = phase_inc[v*PHASE_W +: PHASE_W];
      assign active[v] = voice_on[v] && (inc != '0);
      assign vsamp[v] = active[v] ? shape(acc[v][PHASE_W-1 -: SAMPLE_W], mode) : '0;

      // Inactive voices restart from phase 0 when re-enabled.
      always_ff @(posedge clk) begin
        if (!n_rst) begin
          acc[v] <= '0;
        end else if (tick) begin
          acc[v] <= active[v] ? acc[v] + inc : '0;
        end
      end
    end
  endgenerate

  always_comb begin
    sum      = '0;
    cnt_next = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum      = sum + SUM_W'(vsamp[v]);
      cnt_next = cnt_next + CNT_W'(active[v]);
    end
  end

`ifdef POLY_MIX_SAT_EN
  logic [SUM_W-1:0] scaled;
  always_comb begin
    scaled = sum >> MIX_SH;
    mix    = (scaled > SUM_W'(SMAX)) ? SMAX : scaled[SAMPLE_W-1:0];
  end
`else
  always_comb begin
    mix = SAMPLE_W'(sum >> MIX_SH);
  end
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pwm_cnt      <= '0;
      sample_o     <= '0;
      sample_valid <= 1'b0;
      pwm_o        <= 1'b0;
      active_cnt   <= '0;
    end else begin
      active_cnt   <= cnt_next;
      sample_valid <= tick;
      pwm_o        <= en && (pwm_cnt < sample_o);
      if (en) begin
        pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
      end
      if (tick) begin
        sample_o <= mix;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_poly_synth_core.sv
// tb_poly_synth_core: directed stimulus with a reference model feeding an expected-sample scoreboard.
`default_nettype none

module tb_poly_synth_core;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  voice_on = '0;
  logic [63:0] phase_inc = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  sample_o;
  logic        sample_valid;
  logic        pwm_o;
  logic [2:0]  active_cnt;

  poly_synth_core #(.NUM_VOICES(4), .PHASE_W(16), .SAMPLE_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .voice_on(voice_on), .phase_inc(phase_inc),
    .mode(mode), .sample_o(sample_o), .sample_valid(sample_valid), .pwm_o(pwm_o),
    .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int m_cnt = 0;
  int m_acc [4] = '{0, 0, 0, 0};
  int m_sample = 0;
  int m_pwm = 0;
  int m_act = 0;
  int q [$];
  bit mon_en = 1'b0;

  function automatic int vshape(int a, int md);
    int p;
    p = (a >> 8) & 255;
    case (md)
      0: return (p >= 128) ? 255 : 0;
      1: return p;
      2: return (p >= 128) ? 255 - ((2 * p) & 255) : (2 * p) & 255;
      default: return (p < 64) ? 255 : 0;
    endcase
  endfunction

  function automatic bit is_active(int v);
    return voice_on[v] && (phase_inc[v*16 +: 16] != 16'h0);
  endfunction

  function automatic int model_mix();
    int s;
    s = 0;
    for (int v = 0; v < 4; v++)
      if (is_active(v)) s += vshape(m_acc[v], int'(mode));
`ifdef POLY_MIX_SAT_EN
    s = s / 2;
    return (s > 255) ? 255 : s;
`else
    return s / 4;
`endif
  endfunction

  always @(posedge clk) begin : mdl
    int act;
    if (!n_rst) begin
      m_cnt = 0; m_sample = 0; m_pwm = 0; m_act = 0;
      for (int v = 0; v < 4; v++) m_acc[v] = 0;
      q.delete();
    end else begin
      act = 0;
      for (int v = 0; v < 4; v++) if (is_active(v)) act++;
      m_act = act;
      m_pwm = (en && (m_cnt < m_sample)) ? 1 : 0;
      if (en) begin
        if (m_cnt == 255) begin
          m_sample = model_mix();
          q.push_back(m_sample);
          for (int v = 0; v < 4; v++)
            m_acc[v] = is_active(v) ? (m_acc[v] + int'(phase_inc[v*16 +: 16])) & 16'hFFFF : 0;
        end
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("pwm", pwm_o, m_pwm);
      check("active_cnt", active_cnt, m_act);
      check("sample_hold", sample_o, m_sample);
      if (sample_valid) begin
        if (q.size() == 0) check("valid_unexpected", sample_valid, 0);
        else check("sb_sample", sample_o, q.pop_front());
      end
    end
  end

  task automatic wait_valid(output logic [7:0] s, output int n);
    s = 'x;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        s = sample_o;
        n = i;
        return;
      end
    end
    check("valid_timeout", sample_valid, 1);
  endtask

  task automatic reset_cfg(input logic [3:0] on, input logic [63:0] inc, input logic [1:0] md);
    @(negedge clk);
    n_rst = 1'b0; voice_on = on; phase_inc = inc; mode = md; en = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    logic [7:0] s;
    int n;
    int hi;

    // Reset with live inputs
    en = 1'b1; voice_on = 4'hF; phase_inc = {4{16'h1000}}; mode = 2'b01;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("rst_sample", sample_o, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_pwm", pwm_o, 0);
    check("rst_active", active_cnt, 0);
    n_rst = 1'b1;
    wait_valid(s, n);
    check("first_valid_lat", (n == 256 || n == 257), 1);
    check("first_sample", s, 8'h00);

    // Single saw voice, reset arrives mid-period
    repeat (40) @(negedge clk);
    reset_cfg(4'b0001, 64'h1000, 2'b01);
    for (int k = 0; k < 4; k++) begin
      wait_valid(s, n);
      check("saw_step", s, 4 * k);
    end

    // Four square voices at half rate
    reset_cfg(4'hF, {4{16'h8000}}, 2'b00);
    wait_valid(s, n); check("sq_0", s, 8'h00);
    wait_valid(s, n); check("sq_1", s, 8'hFF);
    hi = int'(pwm_o);
    repeat (255) begin @(negedge clk); hi += int'(pwm_o); end
    check("pwm_high_cnt", hi, 255);
    wait_valid(s, n); check("sq_2", s, 8'h00);
    wait_valid(s, n); check("sq_3", s, 8'hFF);

    // Pause mid-period during a full-scale sample
    repeat (100) @(negedge clk);
    check("pwm_before_pause", pwm_o, 1);
    en = 1'b0;
    @(negedge clk);
    check("pause_pwm_low", pwm_o, 0);
    repeat (50) begin
      @(negedge clk);
      check("pause_sample", sample_o, 8'hFF);
      check("pause_valid", sample_valid, 0);
    end
    en = 1'b1;
    wait_valid(s, n);
    check("resume_lat", n, 156);
    check("resume_sample", s, 8'h00);

    // Voice 2 gated on but with zero increment; then increment changes mid-period
    reset_cfg(4'hF, {16'h1000, 16'h0000, 16'h1000, 16'h1000}, 2'b01);
    @(negedge clk);
    check("active_3", active_cnt, 3);
    wait_valid(s, n); check("zinc_0", s, 8'h00);
    wait_valid(s, n); check("zinc_1", s, 8'h0C);
    wait_valid(s, n); check("zinc_2", s, 8'h18);
    repeat (60) @(negedge clk);
    phase_inc[47:32] = 16'h2000;
    @(negedge clk);
    check("active_4", active_cnt, 4);
    wait_valid(s, n); check("inc_change_0", s, 8'h24);
    wait_valid(s, n); check("inc_change_1", s, 8'h38);

    // Mix gain: two and three voices high
    reset_cfg(4'b0011, {32'h0, 16'h8000, 16'h8000}, 2'b00);
    wait_valid(s, n); check("mix2_0", s, 8'h00);
    wait_valid(s, n);
`ifdef POLY_MIX_SAT_EN
    check("mix2_high", s, 8'hFF);
`else
    check("mix2_high", s, 8'h7F);
`endif
    reset_cfg(4'b0111, {16'h0, 16'h8000, 16'h8000, 16'h8000}, 2'b00);
    wait_valid(s, n); check("mix3_0", s, 8'h00);
    wait_valid(s, n);
`ifdef POLY_MIX_SAT_EN
    check("mix3_high", s, 8'hFF);
`else
    check("mix3_high", s, 8'hBF);
`endif

    // Triangle then pulse, mode changed mid-period
    reset_cfg(4'hF, {16'h4000, 16'h2000, 16'h1000, 16'h0800}, 2'b10);
    repeat (3) wait_valid(s, n);
    repeat (90) @(negedge clk);
    mode = 2'b11;
    repeat (4) wait_valid(s, n);

    @(negedge clk);
    check("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
